// File: rtl/machine_timer.sv
// Machine timer: 64-bit mtime/mtimecmp pair behind a Wishbone slave port,
// with a programmable prescaler and a level timer interrupt.
`timescale 1ns/1ps
module machine_timer #(
  parameter int unsigned PRESCALE_RESET = 0,
  parameter bit          ENABLE_RESET   = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        rty_o,
  output logic        timer_interrupt
);

  localparam logic [15:0] LP_PRESC_RST = PRESCALE_RESET[15:0];

  localparam logic [2:0] OFF_MLO  = 3'd0;
  localparam logic [2:0] OFF_MHI  = 3'd1;
  localparam logic [2:0] OFF_CLO  = 3'd2;
  localparam logic [2:0] OFF_CHI  = 3'd3;
  localparam logic [2:0] OFF_CTRL = 3'd4;

  logic        r_ack, r_err, r_en, r_irq;
  logic [31:0] r_dat;
  logic [63:0] r_mtime, r_mtimecmp;
  logic [15:0] r_pcnt, r_presc;

  logic        w_acc, w_map, w_wr, w_rd, w_tick;
  logic [2:0]  w_off;
  logic [31:0] w_rdata;
  logic        w_unused;

  // Merge byte lanes of a write into the current register word.
  function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = sel[b] ? wd[8*b +: 8] : old[8*b +: 8];
    return res;
  endfunction

  // Decode: a new request is taken only when no termination is pending,
  // which makes a held strobe complete once every two cycles.
  always_comb begin
    w_off  = adr_i[4:2];
    w_acc  = cyc_i & stb_i & ~r_ack & ~r_err;
    w_map  = (w_off <= OFF_CTRL);
    w_wr   = w_acc & we_i & w_map;
    w_rd   = w_acc & ~we_i & w_map;
    w_tick = r_en && (r_pcnt == r_presc);
  end

  // Undecoded address bits.
  assign w_unused = ^{adr_i[31:5], adr_i[1:0]};

  // Read mux over the mapped registers.
  always_comb begin
    w_rdata = '0;
    case (w_off)
      OFF_MLO:  w_rdata = r_mtime[31:0];
      OFF_MHI:  w_rdata = r_mtime[63:32];
      OFF_CLO:  w_rdata = r_mtimecmp[31:0];
      OFF_CHI:  w_rdata = r_mtimecmp[63:32];
      OFF_CTRL: w_rdata = {8'd0, r_presc, 7'd0, r_en};
      default:  w_rdata = '0;
    endcase
  end

  // Bus termination: single-cycle ack/err, read data only alongside ack.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_acc & w_map;
      r_err <= w_acc & ~w_map;
      r_dat <= w_rd ? w_rdata : '0;
    end
  end

  // Prescale counter: restarts on any CTRL write, holds while disabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                       r_pcnt <= '0;
    else if (w_wr && w_off == OFF_CTRL) r_pcnt <= '0;
    else if (w_tick)                   r_pcnt <= '0;
    else if (r_en)                     r_pcnt <= r_pcnt + 16'd1;
  end

  // mtime: a software write to either half wins over that edge's tick.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                       r_mtime <= '0;
    else if (w_wr && w_off == OFF_MLO) r_mtime[31:0]  <= f_merge(r_mtime[31:0], dat_i, sel_i);
    else if (w_wr && w_off == OFF_MHI) r_mtime[63:32] <= f_merge(r_mtime[63:32], dat_i, sel_i);
    else if (w_tick)                   r_mtime <= r_mtime + 64'd1;
  end

  // mtimecmp: byte-lane writes, resets to all ones so no interrupt fires.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                       r_mtimecmp <= '1;
    else if (w_wr && w_off == OFF_CLO) r_mtimecmp[31:0]  <= f_merge(r_mtimecmp[31:0], dat_i, sel_i);
    else if (w_wr && w_off == OFF_CHI) r_mtimecmp[63:32] <= f_merge(r_mtimecmp[63:32], dat_i, sel_i);
  end

  // CTRL: EN in lane 0, PRESCALE in lanes 1 and 2.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_en    <= ENABLE_RESET;
      r_presc <= LP_PRESC_RST;
    end else if (w_wr && w_off == OFF_CTRL) begin
      if (sel_i[0]) r_en          <= dat_i[0];
      if (sel_i[1]) r_presc[7:0]  <= dat_i[15:8];
      if (sel_i[2]) r_presc[15:8] <= dat_i[23:16];
    end
  end

  // Interrupt: registered compare of the pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_irq <= 1'b0;
    else         r_irq <= (r_mtime >= r_mtimecmp);
  end

  assign dat_o           = r_dat;
  assign ack_o           = r_ack;
  assign err_o           = r_err;
  assign rty_o           = 1'b0;
  assign timer_interrupt = r_irq;

endmodule

// File: tb/tb_machine_timer.sv
// Directed bench for machine_timer: register access, prescaling, wrap,
// interrupt level, bus error handling and asynchronous reset.
`timescale 1ns/1ps
module tb_machine_timer;

  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
  logic [31:0] adr_i = '0, dat_i = '0;
  logic [3:0]  sel_i = '0;
  logic [31:0] dat_o;
  logic        ack_o, err_o, rty_o, timer_interrupt;

  localparam logic [31:0] MLO = 32'h00, MHI = 32'h04, CLO = 32'h08, CHI = 32'h0C, CTRL = 32'h10;

  int checks = 0, errors = 0;
  int cnt;

  machine_timer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .adr_i(adr_i), .sel_i(sel_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o),
    .err_o(err_o), .rty_o(rty_o), .timer_interrupt(timer_interrupt)
  );

  always #5 clk_i = ~clk_i;

  // Edges since reset release: after edge k an untouched, enabled,
  // prescale-0 mtime equals k.
  always @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt <= 0;
    else         cnt <= cnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One transaction: accept edge, sample, drop the request, sample again.
  task automatic bus(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                     input logic [31:0] wd, output logic [31:0] rd,
                     output logic a, output logic e, output logic a2);
    @(negedge clk_i);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; sel_i = sel; dat_i = wd;
    @(posedge clk_i); #1;
    rd = dat_o; a = ack_o; e = err_o;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(posedge clk_i); #1;
    a2 = ack_o | err_o;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] wd, input logic [3:0] sel);
    logic [31:0] rd; logic a, e, a2;
    bus(1'b1, adr, sel, wd, rd, a, e, a2);
    chk("wr_term", {a, e, a2}, 3'b100);
  endtask

  task automatic rdr(input logic [31:0] adr, output logic [31:0] rd);
    logic a, e, a2;
    bus(1'b0, adr, 4'hF, 32'h0, rd, a, e, a2);
    chk("rd_term", {a, e, a2}, 3'b100);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, v0, v1, v2;
    logic a, e, a2;
    bit seen;

    // Reset state
    repeat (3) @(posedge clk_i); #1;
    chk("rst_ack", ack_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_dat", dat_o, 32'h0);
    chk("rst_irq", timer_interrupt, 1'b0);
    chk("rty", rty_o, 1'b0);
    @(negedge clk_i); rst_ni = 1'b1;

    // Compare at 0x10 while counting every cycle
    wr(CLO, 32'h10, 4'hF);
    wr(CHI, 32'h0, 4'hF);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (cnt == 16) chk("irq_pre", timer_interrupt, 1'b0);
      if (cnt == 17) begin chk("irq_rise", timer_interrupt, 1'b1); seen = 1'b1; break; end
      @(posedge clk_i); #1;
    end
    chk("irq_seen", seen, 1'b1);
    rdr(MLO, rd);
    chk("mlo_cnt", rd, 32'(cnt - 2));

    // PRESCALE=3 (bits[23:8]), EN=1: one tick every 4 cycles
    wr(CTRL, 32'h0000_0301, 4'hF);
    rdr(CTRL, rd);
    chk("ctrl_rd", rd, 32'h0000_0301);
    rdr(MLO, v0);
    repeat (6) @(posedge clk_i);
    rdr(MLO, v1);
    chk("presc_8cyc", v1 - v0, 32'd2);
    repeat (2) @(posedge clk_i);
    rdr(MLO, v2);
    chk("presc_4cyc", v2 - v1, 32'd1);

    // Carry LO into HI, then full 64-bit wrap
    wr(CTRL, 32'hFFFF_FFFE, 4'hF);
    rdr(CTRL, rd);
    chk("ctrl_mask", rd, 32'h00FF_FF00);
    wr(MLO, 32'hFFFF_FFFF, 4'hF);
    wr(MHI, 32'h0, 4'hF);
    wr(CTRL, 32'h1, 4'hF);
    rdr(MHI, rd);
    chk("carry_hi", rd, 32'h1);
    rdr(MLO, rd);
    chk("carry_lo", rd, 32'h2);
    wr(CTRL, 32'h0, 4'hF);
    wr(MLO, 32'hFFFF_FFFF, 4'hF);
    wr(MHI, 32'hFFFF_FFFF, 4'hF);
    chk("irq_max", timer_interrupt, 1'b1);
    wr(CTRL, 32'h1, 4'hF);
    rdr(MLO, rd);
    chk("wrap_lo", rd, 32'h0);
    rdr(MHI, rd);
    chk("wrap_hi", rd, 32'h0);
    chk("irq_wrap", timer_interrupt, 1'b0);

    // Unmapped offsets terminate with err and change nothing
    bus(1'b0, 32'h14, 4'hF, 32'h0, rd, a, e, a2);
    chk("err_rd_term", {a, e, a2}, 3'b010);
    chk("err_rd_dat", rd, 32'h0);
    bus(1'b1, 32'h14, 4'hF, 32'hFFFF_FFFF, rd, a, e, a2);
    chk("err_wr_term", {a, e, a2}, 3'b010);
    bus(1'b1, 32'h1C, 4'hF, 32'h0, rd, a, e, a2);
    chk("err_wr1c_term", {a, e, a2}, 3'b010);
    rdr(CTRL, rd);
    chk("err_ctrl", rd, 32'h1);
    rdr(CLO, rd);
    chk("err_clo", rd, 32'h10);
    rdr(CHI, rd);
    chk("err_chi", rd, 32'h0);
    rdr(32'h0000_0110, rd);
    chk("adr_alias", rd, 32'h1);

    // Level interrupt held until compare moves above mtime
    wr(CTRL, 32'h0, 4'hF);
    wr(MLO, 32'h20, 4'hF);
    wr(MHI, 32'h0, 4'hF);
    chk("irq_set", timer_interrupt, 1'b1);
    repeat (3) @(posedge clk_i);
    rdr(MLO, rd);
    chk("hold_mlo", rd, 32'h20);
    chk("irq_hold", timer_interrupt, 1'b1);
    wr(CLO, 32'h30, 4'hF);
    chk("irq_clr", timer_interrupt, 1'b0);

    // Held strobe: ack toggles, data only in ack cycles
    @(negedge clk_i);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = MLO; sel_i = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      chk("stream_ack", ack_o, (i % 2 == 0));
      chk("stream_dat", dat_o, (i % 2 == 0) ? 32'h20 : 32'h0);
    end
    cyc_i = 1'b0; stb_i = 1'b0;

    // Asynchronous reset in the ack cycle while counting
    wr(CTRL, 32'h1, 4'hF);
    wr(CLO, 32'h0, 4'hF);
    chk("irq_on", timer_interrupt, 1'b1);
    @(negedge clk_i);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = MLO;
    @(posedge clk_i); #1;
    chk("abort_ack_pre", ack_o, 1'b1);
    #1 rst_ni = 1'b0;
    #1;
    chk("abort_ack", ack_o, 1'b0);
    chk("abort_irq", timer_interrupt, 1'b0);
    chk("abort_dat", dat_o, 32'h0);
    chk("abort_mtime", dut.r_mtime, 64'h0);
    cyc_i = 1'b0; stb_i = 1'b0;
    @(negedge clk_i); rst_ni = 1'b1;

    // Reset values and byte-lane write
    rdr(CTRL, rd);
    chk("rst_ctrl", rd, 32'h1);
    rdr(CHI, rd);
    chk("rst_chi", rd, 32'hFFFF_FFFF);
    rdr(MLO, rd);
    chk("rst_mlo_cnt", rd, 32'(cnt - 2));
    wr(CLO, 32'hAABB_CCDD, 4'b0100);
    rdr(CLO, rd);
    chk("sel_lane2", rd, 32'hFFBB_FFFF);
    chk("rst_irq_after", timer_interrupt, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
